hq2x_sequencer: RTL and testbench
=================================

// Module: hq2x_sequencer
// PURPOSE
//  Timing/strobe sequencer for the Hq2x scaler core. From the core's native pixel strobe and blanks it derives:
//  - the 4x-rate ce_in/ce_out strobe the scaler needs (4 internal cycles per input pixel);
//  - the reset_line/reset_frame edges the scaler needs;
//  - read_y (output sub-line and buffer select);
//  - doubled-line hblank/vblank for the output side.
//  Sits between the core video timing and Hq2x; has no pixel datapath.
// PARAMETERS
//  LENGTH   768  max input pixels per line (matches Hq2x LENGTH); sets counter widths
//  PW       5    width of pixel-period measurement (clk cycles per ce_pix, max 2**PW-1)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  ce_pix       in   1   input pixel strobe; >=4 clk apart
//  hblank_in    in   1   input horizontal blank, sampled on ce_pix
//  vblank_in    in   1   input vertical blank, sampled on ce_pix
//  ce_hq        out  1   4x pixel strobe -> Hq2x ce_in and ce_out
//  reset_line   out  1   -> Hq2x reset_line
//  reset_frame  out  1   -> Hq2x reset_frame
//  read_y       out  2   -> Hq2x read_y; [0] output sub-line, [1] buffer of completed line
//  hblank_out   out  1   doubled-line hblank -> Hq2x hblank and downstream
//  vblank_out   out  1   vblank delayed one input line
//  period_err   out  1   sticky: last measured pixel period <4 clk; cleared at vblank_in rise
//  len_ovf      out  1   sticky: active width > LENGTH; cleared at vblank_in rise
// BEHAVIOUR
//  Reset values (all regs, including internal counters/flags):
//   ce_hq=0, reset_line=1, reset_frame=1, read_y=0, hblank_out=1, vblank_out=1, period_err=0, len_ovf=0.
//   Reset asserted mid-line aborts all counters; first ce_pix after release starts period measurement afresh.
//  Period measurement:
//   - P = clk count between consecutive ce_pix, latched at each ce_pix.
//   - The first ce_pix after reset uses P=4 until a full interval is measured.
//  ce_hq generator (phase accumulator, acc PW+2 bits, k = pulse count):
//   - On ce_pix: ce_hq=1, acc<=0, k<=1.
//   - Else: n=acc+4; if n>=P and k<4 then ce_hq=1, acc<=n-P, k++; else acc<=n.
//   - Exactly 4 pulses per pixel for constant P>=4. For P<4: pulse only on ce_pix, set period_err.
//   - ce_hq is combinationally derived from a registered state, no cycle of latency beyond the ce_pix cycle.
//  Line control:
//   - reset_line <= hblank_in and reset_frame <= vblank_in, both updated on ce_pix. Hq2x sees edges on ce_hq.
//   - A = count of ce_pix with hblank_in=0 on the previous line, latched at hblank_in rise.
//   - H = total ce_pix per input line, latched at hblank_in fall. Clamp A to LENGTH and set len_ovf if exceeded.
//  Output timing (counter ox in ce_hq units):
//   - At hblank_in fall: ox<=0, read_y[0]<=0.
//   - Otherwise ox++ on ce_hq. At ox==2H-1: ox<=0 and read_y[0]<=1. Sub-line 1 never wraps to 2; it holds until the next hblank_in fall.
//   - hblank_out = (ox >= 2A). Registered, updated on ce_hq. Hold 1 while A==0.
//  Buffer mirror:
//   - wbuf toggles at each hblank_in fall; read_y[1] <= wbuf value before toggle.
//   - If vblank_in fell since the previous hblank_in fall, wbuf<=0 and read_y[1]<=0.
//  Vertical:
//   - vblank_out <= vblank_in value captured at the previous hblank_in fall (one input line delay).
//  Simultaneous events:
//   - reset has priority over all.
//   - hblank_in fall coincident with ox wrap: the fall wins (ox<=0, read_y[0]<=0).
//   - Sticky flag set coincident with clear: clear wins.
// STRUCTURE
//  hq2x_pkg: LENGTH-derived widths (XW=$clog2(LENGTH)+2), PW default, constant CE_PER_PIX=4.
//  Sub-module hq2x_ce_gen: period measurement + phase accumulator -> ce_hq, period_err.
//  Top: line/frame edge detect, A/H capture, ox counter, read_y, blanks.
// TESTING
//  1. ce_pix every 8 clk -> ce_hq at pixel offsets 0,2,4,6; exactly 4 per pixel over 100 pixels.
//  2. ce_pix every 6 clk -> ce_hq at offsets 0,2,3,5; none lost or extra; P=4 -> ce_hq every clk.
//  3. ce_pix every 3 clk -> period_err=1, one ce_hq per ce_pix; vblank_in rise clears it.
//  4. A=4, H=6 -> per input line: hblank_out 0 for 8 ce_hq, 1 for 4, read_y[0] toggles 0->1 at ce_hq 12, 0 at next line.
//  5. 3 lines after vblank fall -> read_y[1]=0,0,1; vblank_out low from 2nd active line; A=800 with LENGTH=768 -> len_ovf.
//  6. reset pulsed mid-line -> all outputs at reset values next clk; clean timing from next hblank_in fall.

Source files
------------

// File: rtl/hq2x_pkg.sv
// hq2x_pkg: shared constants and width helper for the Hq2x timing sequencer
package hq2x_pkg;
  localparam int LENGTH_DEF = 768;
  localparam int PW_DEF = 5;
  localparam int CE_PER_PIX = 4;
  function automatic int xw(input int len);
    return $clog2(len) + 2;
  endfunction
endpackage

// File: rtl/hq2x_ce_gen.sv
// hq2x_ce_gen: measures the pixel period and spreads four ce_hq strobes across it
module hq2x_ce_gen import hq2x_pkg::*; #(
  parameter int PW = PW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ce_pix,
  input  logic clr,
  output logic ce_hq,
  output logic period_err
);
  logic [PW-1:0] cnt, p;
  logic [PW+1:0] acc, n;
  logic [2:0] k;
  logic seen;
  // Pulses beyond the pixel strobe need a period long enough to hold all four
  always_comb begin
    n = acc + (PW+2)'(CE_PER_PIX);
    ce_hq = ce_pix | (n >= (PW+2)'(p) && k < 3'(CE_PER_PIX) && p >= PW'(CE_PER_PIX));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      p <= PW'(CE_PER_PIX);
      acc <= '0;
      k <= 3'(CE_PER_PIX);
      seen <= 1'b0;
      period_err <= 1'b0;
    end else begin
      cnt <= ce_pix ? PW'(1) : (&cnt ? cnt : cnt + 1'b1);
      if (ce_pix) begin
        acc <= '0;
        k <= 3'd1;
        seen <= 1'b1;
        p <= seen ? cnt : PW'(CE_PER_PIX);
      end else if (k < 3'(CE_PER_PIX)) begin
        acc <= ce_hq ? n - (PW+2)'(p) : n;
        k <= k + 3'(ce_hq);
      end
      period_err <= clr ? 1'b0 : period_err | (ce_pix & seen & (cnt < PW'(CE_PER_PIX)));
    end
  end
endmodule

// File: rtl/hq2x_sequencer.sv
// hq2x_sequencer: derives Hq2x strobes, line/frame resets, read_y and doubled-line blanks
module hq2x_sequencer import hq2x_pkg::*; #(
  parameter int LENGTH = LENGTH_DEF,
  parameter int PW = PW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_pix,
  input  logic hblank_in,
  input  logic vblank_in,
  output logic ce_hq,
  output logic reset_line,
  output logic reset_frame,
  output logic [1:0] read_y,
  output logic hblank_out,
  output logic vblank_out,
  output logic period_err,
  output logic len_ovf
);
  localparam int W = xw(LENGTH);
  logic hfall, hrise, vfall, vrise, vfell, wbuf, vb_line, ox_wrap;
  logic [W-1:0] act, tot, a, h;
  logic [W:0] ox, ox_nx;
  hq2x_ce_gen #(.PW(PW)) u_ce (
    .clk(clk), .rst(reset), .ce_pix(ce_pix), .clr(vrise), .ce_hq(ce_hq), .period_err(period_err)
  );
  // reset_line/reset_frame double as the previous blank samples for edge detection
  always_comb begin
    hfall = ce_pix & ~hblank_in & reset_line;
    hrise = ce_pix & hblank_in & ~reset_line;
    vfall = ce_pix & ~vblank_in & reset_frame;
    vrise = ce_pix & vblank_in & ~reset_frame;
    ox_wrap = (ox + 1'b1) == {h, 1'b0};
    ox_nx = hfall ? '0 : ox_wrap ? (read_y[0] ? ox : '0) : ox + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      reset_line <= 1'b1;
      reset_frame <= 1'b1;
      read_y <= 2'b00;
      hblank_out <= 1'b1;
      vblank_out <= 1'b1;
      len_ovf <= 1'b0;
      act <= '0;
      tot <= '0;
      a <= '0;
      h <= '0;
      ox <= '0;
      wbuf <= 1'b0;
      vfell <= 1'b0;
      vb_line <= 1'b1;
    end else begin
      if (ce_pix) begin
        reset_line <= hblank_in;
        reset_frame <= vblank_in;
      end
      if (hrise) begin
        a <= act > W'(LENGTH) ? W'(LENGTH) : act;
        act <= '0;
      end else if (ce_pix & ~hblank_in & ~&act) act <= act + 1'b1;
      len_ovf <= vrise ? 1'b0 : len_ovf | (hrise & (act > W'(LENGTH)));
      if (hfall) begin
        h <= tot;
        tot <= W'(1);
        wbuf <= (vfell | vfall) ? 1'b0 : ~wbuf;
        read_y[1] <= (vfell | vfall) ? 1'b0 : wbuf;
        vfell <= 1'b0;
        vb_line <= vblank_in;
        vblank_out <= vb_line;
      end else begin
        if (ce_pix & ~&tot) tot <= tot + 1'b1;
        if (vfall) vfell <= 1'b1;
      end
      if (ce_hq) begin
        ox <= ox_nx;
        hblank_out <= ox_nx >= {a, 1'b0};
        read_y[0] <= hfall ? 1'b0 : (ox_wrap | read_y[0]);
      end
    end
  end
endmodule

// File: tb/tb_hq2x_sequencer.sv
// tb_hq2x_sequencer: scoreboard bench for strobe spacing, line timing, buffers and sticky flags
module tb_hq2x_sequencer;
  logic clk = 0, reset = 1, ce_pix = 0, hblank_in = 1, vblank_in = 1;
  logic ce_hq, reset_line, reset_frame, hblank_out, vblank_out, period_err, len_ovf;
  logic [1:0] read_y;
  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_m[$];
  logic [1:0] exp_o[$], obs[$], exp_v[$];
  logic prev_ce = 0;
  logic [8:0] rst_vec = 9'b011001100;

  hq2x_sequencer dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hblank_in(hblank_in), .vblank_in(vblank_in),
    .ce_hq(ce_hq), .reset_line(reset_line), .reset_frame(reset_frame), .read_y(read_y),
    .hblank_out(hblank_out), .vblank_out(vblank_out), .period_err(period_err), .len_ovf(len_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prev_ce) obs.push_back({read_y[0], hblank_out});
    prev_ce <= ce_hq;
  end

  task automatic pix(input int p, input logic hb, input logic vb, output logic [31:0] m);
    m = '0;
    for (int i = 0; i < p; i++) begin
      ce_pix = (i == 0);
      hblank_in = hb;
      vblank_in = vb;
      @(negedge clk);
      if (ce_hq) m[i] = 1'b1;
      @(posedge clk);
      #1;
    end
    ce_pix = 0;
  endtask

  task automatic line(input int act, input int tot, input logic vb, input int p);
    logic [31:0] m;
    for (int i = 0; i < tot; i++) pix(p, i >= act, vb, m);
  endtask

  task automatic test_reset();
    logic [31:0] m;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if ({ce_hq, reset_line, reset_frame, read_y, hblank_out, vblank_out, period_err, len_ovf} !== rst_vec) begin
      n_err++;
      $display("FAIL reset_values: got %b want %b",
        {ce_hq, reset_line, reset_frame, read_y, hblank_out, vblank_out, period_err, len_ovf}, rst_vec);
    end
    @(posedge clk);
    #1;
    reset = 0;
    exp_m.push_back(32'hF);
    pix(8, 1, 0, m);
    n_cmp++;
    if (m !== exp_m.pop_front()) begin
      n_err++;
      $display("FAIL first_pixel_p4: got %h want %h", m, 32'hF);
    end
  endtask

  task automatic test_ce8();
    logic [31:0] m, e;
    int total = 0;
    pix(8, 1, 0, m);
    for (int i = 0; i < 100; i++) begin
      exp_m.push_back(32'h55);
      pix(8, 1, 0, m);
      total += $countones(m);
      e = exp_m.pop_front();
      n_cmp++;
      if (m !== e) begin
        n_err++;
        $display("FAIL ce8_pixel %0d: got %h want %h", i, m, e);
      end
    end
    n_cmp++;
    if (total !== 400) begin
      n_err++;
      $display("FAIL ce8_total: got %0d want 400", total);
    end
  endtask

  task automatic test_ce6_ce4();
    logic [31:0] m, e;
    pix(6, 1, 0, m);
    for (int i = 0; i < 20; i++) begin
      exp_m.push_back(32'h2D);
      pix(6, 1, 0, m);
      e = exp_m.pop_front();
      n_cmp++;
      if (m !== e) begin
        n_err++;
        $display("FAIL ce6_pixel %0d: got %h want %h", i, m, e);
      end
    end
    pix(4, 1, 0, m);
    for (int i = 0; i < 20; i++) begin
      exp_m.push_back(32'hF);
      pix(4, 1, 0, m);
      e = exp_m.pop_front();
      n_cmp++;
      if (m !== e) begin
        n_err++;
        $display("FAIL ce4_pixel %0d: got %h want %h", i, m, e);
      end
    end
  endtask

  task automatic test_ce3();
    logic [31:0] m, e;
    pix(3, 1, 0, m);
    for (int i = 0; i < 10; i++) begin
      exp_m.push_back(32'h1);
      pix(3, 1, 0, m);
      e = exp_m.pop_front();
      n_cmp++;
      if (m !== e) begin
        n_err++;
        $display("FAIL ce3_pixel %0d: got %h want %h", i, m, e);
      end
    end
    n_cmp++;
    if (period_err !== 1'b1) begin
      n_err++;
      $display("FAIL period_err_set: got %b want 1", period_err);
    end
    pix(8, 1, 1, m);
    n_cmp++;
    if (period_err !== 1'b0) begin
      n_err++;
      $display("FAIL period_err_clear: got %b want 0", period_err);
    end
    pix(8, 1, 1, m);
    n_cmp++;
    if (period_err !== 1'b0) begin
      n_err++;
      $display("FAIL period_err_stays_clear: got %b want 0", period_err);
    end
  endtask

  task automatic test_line_timing();
    logic [1:0] e, o;
    line(4, 6, 0, 8);
    line(4, 6, 0, 8);
    for (int j = 0; j < 24; j++) exp_o.push_back({j >= 12, (j % 12) >= 8});
    obs.delete();
    line(4, 6, 0, 8);
    n_cmp++;
    if (obs.size() !== 24) begin
      n_err++;
      $display("FAIL line_ce_count: got %0d want 24", obs.size());
    end
    for (int j = 0; j < 24; j++) begin
      e = exp_o.pop_front();
      o = (j < obs.size()) ? obs[j] : 2'bxx;
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL line_ce %0d {read_y0,hblank_out}: got %b want %b", j, o, e);
      end
    end
  endtask

  task automatic test_vblank();
    logic [1:0] e;
    line(4, 6, 1, 8);
    line(4, 6, 1, 8);
    exp_v.push_back(2'b01);
    exp_v.push_back(2'b00);
    exp_v.push_back(2'b10);
    for (int l = 0; l < 3; l++) begin
      line(4, 6, 0, 8);
      e = exp_v.pop_front();
      n_cmp++;
      if ({read_y[1], vblank_out} !== e) begin
        n_err++;
        $display("FAIL vline %0d {read_y1,vblank_out}: got %b want %b", l, {read_y[1], vblank_out}, e);
      end
    end
  endtask

  task automatic test_len_ovf();
    logic [31:0] m;
    n_cmp++;
    if (len_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL len_ovf_idle: got %b want 0", len_ovf);
    end
    line(800, 802, 0, 4);
    n_cmp++;
    if (len_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL len_ovf_set: got %b want 1", len_ovf);
    end
    pix(8, 1, 1, m);
    n_cmp++;
    if (len_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL len_ovf_clear: got %b want 0", len_ovf);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] m;
    line(4, 6, 0, 8);
    pix(8, 0, 0, m);
    pix(8, 0, 0, m);
    reset = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if ({ce_hq, reset_line, reset_frame, read_y, hblank_out, vblank_out, period_err, len_ovf} !== rst_vec) begin
      n_err++;
      $display("FAIL midline_reset: got %b want %b",
        {ce_hq, reset_line, reset_frame, read_y, hblank_out, vblank_out, period_err, len_ovf}, rst_vec);
    end
    @(posedge clk);
    #1;
    exp_m.push_back(32'hF);
    pix(8, 0, 0, m);
    n_cmp++;
    if (m !== exp_m.pop_front()) begin
      n_err++;
      $display("FAIL reset_first_pixel: got %h want %h", m, 32'hF);
    end
    pix(8, 0, 0, m);
    pix(8, 1, 0, m);
    pix(8, 1, 0, m);
    test_line_timing();
  endtask

  initial begin
    test_reset();
    test_ce8();
    test_ce6_ce4();
    test_ce3();
    test_line_timing();
    test_vblank();
    test_len_ovf();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
